// File: rtl/slave_mem_ctrl.sv
// slave_mem_ctrl: memory-side controller behind the serial bus slave.
// Services one read/write at a time with fixed per-direction latency.
module slave_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = 4096,
  parameter int WRITE_LATENCY = 1,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     write_en_internal,
  input  logic                     req_int_data,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    wdata_in,
  output logic                     module_dv,
  output logic [DATA_WIDTH-1:0]    rdata_out,
  output logic                     busy,
  output logic                     range_err,
  output logic                     proto_err
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] DEPTH =
    (ADDRESS_WIDTH+1)'(MEM_DEPTH);
  localparam logic [3:0] WL0 = 4'(WRITE_LATENCY - 1);
  localparam logic [3:0] RL0 = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE, WRITE_WAIT, READ_WAIT, DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]            lat_cnt;
  logic [IW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic accept, waiting, cnt_zero;
  logic wr_go, rd_go, oor;

  // DONE is about to return to IDLE, so it can take the next request
  assign accept   = (state == IDLE) || (state == DONE);
  assign waiting  = (state == WRITE_WAIT) || (state == READ_WAIT);
  assign cnt_zero = (lat_cnt == 4'd0);
  assign wr_go    = accept & write_en_internal;
  assign rd_go    = accept & req_int_data & ~write_en_internal;
  assign oor      = ({1'b0, addr_in} >= DEPTH);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (wr_go)      state_nxt = WRITE_WAIT;
        else if (rd_go) state_nxt = READ_WAIT;
        else            state_nxt = IDLE;
      end
      WRITE_WAIT: if (cnt_zero) state_nxt = DONE;
      READ_WAIT:  if (cnt_zero) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    module_dv = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:       busy = 1'b0;
      WRITE_WAIT: busy = 1'b1;
      READ_WAIT:  busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        module_dv = 1'b1;
      end
      default: ;
    endcase
  end

  // request capture, latency countdown, read data and error flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      range_err <= 1'b0;
      rdata_out <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= (waiting & (write_en_internal | req_int_data))
                 | (accept & write_en_internal & req_int_data);
      if (wr_go) begin
        addr_q    <= addr_in[IW-1:0];
        wdata_q   <= wdata_in;
        lat_cnt   <= WL0;
        range_err <= oor;
      end else if (rd_go) begin
        addr_q    <= addr_in[IW-1:0];
        lat_cnt   <= RL0;
        range_err <= oor;
      end else if (waiting && !cnt_zero) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (state == READ_WAIT && cnt_zero)
        rdata_out <= range_err ? '0 : mem[addr_q];
    end
  end

  // storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (state == WRITE_WAIT && cnt_zero && !range_err)
      mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_slave_mem_ctrl.sv
// tb_slave_mem_ctrl: directed checks of slave_mem_ctrl.
// Default instance plus two latency-corner instances.
module tb_slave_mem_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [14:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        dv, busy, rerr, perr;
  logic [7:0]  rdata;

  logic        we_a = 1'b0, re_a = 1'b0;
  logic        we_b = 1'b0, re_b = 1'b0;
  logic        dv_a, busy_a, rerr_a, perr_a;
  logic        dv_b, busy_b, rerr_b, perr_b;
  logic [7:0]  rdata_a, rdata_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  slave_mem_ctrl dut (
    .clk(clk), .rstn(rstn),
    .write_en_internal(we), .req_int_data(re),
    .addr_in(addr), .wdata_in(wdata),
    .module_dv(dv), .rdata_out(rdata),
    .busy(busy), .range_err(rerr), .proto_err(perr)
  );

  slave_mem_ctrl #(.WRITE_LATENCY(15), .READ_LATENCY(1)) u_a (
    .clk(clk), .rstn(rstn),
    .write_en_internal(we_a), .req_int_data(re_a),
    .addr_in(addr), .wdata_in(wdata),
    .module_dv(dv_a), .rdata_out(rdata_a),
    .busy(busy_a), .range_err(rerr_a), .proto_err(perr_a)
  );

  slave_mem_ctrl #(.WRITE_LATENCY(1), .READ_LATENCY(15)) u_b (
    .clk(clk), .rstn(rstn),
    .write_en_internal(we_b), .req_int_data(re_b),
    .addr_in(addr), .wdata_in(wdata),
    .module_dv(dv_b), .rdata_out(rdata_b),
    .busy(busy_b), .range_err(rerr_b), .proto_err(perr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pulse request; returns 1ns after the request edge E0
  task automatic issue(input bit w, input bit r,
                       input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  // count edges after E0 until the chosen instance raises module_dv
  task automatic measure(input int which, input bit w,
                         input int exp, input string tag);
    int lat;
    bit seen;
    lat = -1;
    seen = 1'b0;
    @(negedge clk);
    addr = 15'h0003; wdata = 8'h5A;
    if (which == 0) begin we_a = w; re_a = !w; end
    else            begin we_b = w; re_b = !w; end
    @(posedge clk);
    #1;
    we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      step();
      if ((which == 0) ? dv_a : dv_b) begin
        lat = k;
        seen = 1'b1;
      end
    end
    chk(tag, lat, exp);
    step();
    step();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_perr", perr, 0);
    @(negedge clk);
    rstn = 1'b1;

    // write 0xA5 to 0x0005, WRITE_LATENCY=1
    issue(1, 0, 15'h0005, 8'hA5);
    chk("wr_busy_e0", busy, 1);
    chk("wr_dv_e0", dv, 0);
    step();
    chk("wr_dv_e1", dv, 1);
    chk("wr_busy_e1", busy, 1);
    chk("wr_rerr", rerr, 0);
    step();
    chk("wr_dv_e2", dv, 0);
    chk("wr_busy_e2", busy, 0);
    chk("wr_perr", perr, 0);

    // read back 0x0005, READ_LATENCY=2
    issue(0, 1, 15'h0005, 8'h00);
    chk("rd_dv_e0", dv, 0);
    step();
    chk("rd_dv_e1", dv, 0);
    step();
    chk("rd_dv_e2", dv, 1);
    chk("rd_data", rdata, 8'hA5);
    step();
    chk("rd_dv_e3", dv, 0);
    chk("rd_hold", rdata, 8'hA5);

    // out-of-range write/read must not alias onto word 0
    issue(1, 0, 15'h0000, 8'h11);
    repeat (2) step();
    issue(1, 0, 15'h1000, 8'h3C);
    step();
    chk("oor_wr_dv", dv, 1);
    chk("oor_wr_rerr", rerr, 1);
    step();
    issue(0, 1, 15'h1000, 8'h00);
    repeat (2) step();
    chk("oor_rd_dv", dv, 1);
    chk("oor_rd_data", rdata, 8'h00);
    chk("oor_rd_rerr", rerr, 1);
    step();
    issue(0, 1, 15'h0000, 8'h00);
    repeat (2) step();
    chk("oor_mem0", rdata, 8'h11);
    chk("oor_clr_rerr", rerr, 0);
    step();

    // read pulse during WRITE_WAIT is ignored
    issue(1, 0, 15'h0007, 8'h77);
    re = 1'b1;
    step();
    re = 1'b0;
    chk("pe_ww_dv", dv, 1);
    chk("pe_ww_perr", perr, 1);
    step();
    chk("pe_ww_perr_off", perr, 0);
    chk("pe_ww_idle", busy, 0);
    issue(0, 1, 15'h0007, 8'h00);
    repeat (2) step();
    chk("pe_ww_data", rdata, 8'h77);
    step();

    // simultaneous write+read in IDLE
    issue(1, 1, 15'h0009, 8'h99);
    chk("pe_both_perr", perr, 1);
    chk("pe_both_busy", busy, 1);
    step();
    chk("pe_both_dv", dv, 1);
    chk("pe_both_perr_off", perr, 0);
    chk("pe_both_rdata", rdata, 8'h77);
    step();
    chk("pe_both_idle", busy, 0);
    issue(0, 1, 15'h0009, 8'h00);
    repeat (2) step();
    chk("pe_both_data", rdata, 8'h99);
    step();

    // reset while in READ_WAIT
    issue(0, 1, 15'h0000, 8'h00);
    chk("mr_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_rdata", rdata, 0);
    chk("mr_dv", dv, 0);
    step();
    step();
    chk("mr_dv_hold", dv, 0);
    chk("mr_busy_hold", busy, 0);
    @(negedge clk);
    rstn = 1'b1;
    issue(0, 1, 15'h0005, 8'h00);
    repeat (2) step();
    chk("mr_dv_after", dv, 1);
    chk("mr_data_after", rdata, 8'hA5);
    step();

    // latency corners
    measure(0, 1, 15, "lat_w15");
    measure(0, 0, 1, "lat_r1");
    measure(1, 1, 1, "lat_w1");
    measure(1, 0, 15, "lat_r15");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
